// File: rtl/ram_1w2r.sv
`default_nettype none
// ============================================================================
//  Module      : ram_1w2r
//  Description : Single-clock RAM with one read/write port (A) and one
//                read-only port (B). Both reads are registered (1-cycle
//                latency). Port A is write-first; port B bypasses the write
//                data when it reads the address port A is writing. After
//                reset the whole array is cleared to zero, one word per
//                cycle, before accesses are honoured (ready=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_1w2r #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [WIDTH-1:0]      dina,
  output logic [WIDTH-1:0]      douta,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [WIDTH-1:0]      doutb,
  output logic                  ready
);

  localparam int                    c_depth     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

  // CLEAR is the all-zero encoding so a zero-initialised state register
  // lands in CLEAR at power-up without needing a reset pulse.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  logic [WIDTH-1:0]      mem [c_depth];

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_d;
  logic [WIDTH-1:0]      douta_q;
  logic [WIDTH-1:0]      douta_d;
  logic [WIDTH-1:0]      doutb_q;
  logic [WIDTH-1:0]      doutb_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  collide;

  assign collide = wea && (addrb == addra);

  // Controller next-state, clear counter, array write port and read data.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    douta_d   = '0;
    doutb_d   = '0;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = '0;

    case (state_q)
      ST_CLEAR: begin
        // Zero one word per cycle; user writes are ignored and outputs held at 0.
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == c_last_addr) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Port A is write-first; port B sees old data unless it hits the write.
        douta_d = wea     ? dina : mem[addra];
        doutb_d = collide ? dina : mem[addrb];
        if (wea) begin
          mem_we    = 1'b1;
          mem_waddr = addra;
          mem_wdata = dina;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase

    // Reset wins over any write presented on the same edge.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  // Controller and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      douta_q   <= '0;
      doutb_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      douta_q   <= douta_d;
      doutb_q   <= doutb_d;
    end
  end

  // Storage array write; kept reset-free so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign douta = douta_q;
  assign doutb = doutb_q;
  assign ready = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_ram_1w2r.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_1w2r
//  Description : Directed self-checking bench for ram_1w2r (default sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_1w2r;

  logic       clk;
  logic       rst;
  logic       wea;
  logic [7:0] addra;
  logic [7:0] dina;
  logic [7:0] douta;
  logic [7:0] addrb;
  logic [7:0] doutb;
  logic       ready;

  int vectors;
  int miscompares;

  logic [7:0] vals [5];

  ram_1w2r #(.WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
    .addrb (addrb),
    .doutb (doutb),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until ready rises (bounded); report steps taken and any nonzero output seen.
  task automatic wait_ready(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (ready !== 1'b1 && n < 400) begin
      if (douta !== 8'h00 || doutb !== 8'h00) bad++;
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int bad;
    vectors     = 0;
    miscompares = 0;
    vals[0] = 8'h3C; vals[1] = 8'h30; vals[2] = 8'h07; vals[3] = 8'h2A; vals[4] = 8'hFE;

    rst = 1'b1; wea = 1'b0; addra = 8'h00; dina = 8'h00; addrb = 8'h00;
    step();
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_douta", {24'b0, douta}, 32'h00);
    check("reset_doutb", {24'b0, doutb}, 32'h00);

    // Clear phase with a write attempt to address 10 that must be ignored.
    rst = 1'b0; wea = 1'b1; addra = 8'd10; dina = 8'h77; addrb = 8'd10;
    wait_ready(n, bad);
    check("clear_len", n, 32'd256);
    check("clear_outs_zero", bad, 32'd0);
    check("clear_ready", {31'b0, ready}, 32'd1);
    check("clear_last_douta", {24'b0, douta}, 32'h00);

    // Writes with addrb == addra: write-first on A, bypass on B.
    for (int k = 0; k < 5; k++) begin
      wea = 1'b1; addra = 8'(k); dina = vals[k]; addrb = 8'(k);
      step();
      check($sformatf("wr%0d_douta", k), {24'b0, douta}, {24'b0, vals[k]});
      check($sformatf("wr%0d_doutb", k), {24'b0, doutb}, {24'b0, vals[k]});
    end

    // Read back: B sweeps up, A sweeps down independently.
    wea = 1'b0;
    for (int k = 0; k < 5; k++) begin
      addrb = 8'(k); addra = 8'(4 - k);
      step();
      check($sformatf("rd%0d_doutb", k), {24'b0, doutb}, {24'b0, vals[k]});
      check($sformatf("rd%0d_douta", k), {24'b0, douta}, {24'b0, vals[4-k]});
    end
    addrb = 8'd5; addra = 8'd10;
    step();
    check("rd5_doutb", {24'b0, doutb}, 32'h00);
    check("rd10_douta_clear_write_ignored", {24'b0, douta}, 32'h00);

    // Write to 1 while B reads 2: B gets old contents.
    wea = 1'b1; addra = 8'd1; dina = 8'h55; addrb = 8'd2;
    step();
    check("nocoll_doutb", {24'b0, doutb}, 32'h07);
    check("nocoll_douta", {24'b0, douta}, 32'h55);
    // Collision with a different old value must return the new data.
    addra = 8'd2; dina = 8'h99; addrb = 8'd2;
    step();
    check("coll_doutb", {24'b0, doutb}, 32'h99);
    check("coll_douta", {24'b0, douta}, 32'h99);
    wea = 1'b0; addra = 8'd1; addrb = 8'd2;
    step();
    check("rb1_douta", {24'b0, douta}, 32'h55);
    check("rb2_doutb", {24'b0, doutb}, 32'h99);
    // Outputs hold while addresses stay and no write occurs.
    step();
    check("hold_douta", {24'b0, douta}, 32'h55);

    // Reset during RUN with a simultaneous write to address 3.
    rst = 1'b1; wea = 1'b1; addra = 8'd3; dina = 8'hAA; addrb = 8'd3;
    step();
    check("rst_run_ready", {31'b0, ready}, 32'd0);
    check("rst_run_douta", {24'b0, douta}, 32'h00);
    check("rst_run_doutb", {24'b0, doutb}, 32'h00);
    rst = 1'b0; wea = 1'b0;
    // Partial clear, then reset again: clear must restart from scratch.
    for (int i = 0; i < 50; i++) step();
    check("partial_clear_ready", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(n, bad);
    check("reclear_len", n, 32'd256);
    check("reclear_outs_zero", bad, 32'd0);

    addra = 8'd3; addrb = 8'd2;
    step();
    check("rst_write_discarded", {24'b0, douta}, 32'h00);
    check("reclear_addr2", {24'b0, doutb}, 32'h00);
    addra = 8'd0; addrb = 8'd4;
    step();
    check("reclear_addr0", {24'b0, douta}, 32'h00);
    check("reclear_addr4", {24'b0, doutb}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_1w2r.md
RAM_1W2R -- requirements
Module: ram_1w2r

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits (first positional parameter).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: address width; depth = 2^ADDR_WIDTH words (second positional parameter).
REQ-003 SHALL have port clk, input, 1 bit: single clock for both ports; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port wea, input, 1 bit: write enable for port A.
REQ-006 SHALL have port addra, input, ADDR_WIDTH bits: port A read/write address.
REQ-007 SHALL have port dina, input, WIDTH bits: port A write data.
REQ-008 SHALL have port douta, output, WIDTH bits: port A registered read data.
REQ-009 SHALL have port addrb, input, ADDR_WIDTH bits: port B read-only address.
REQ-010 SHALL have port doutb, output, WIDTH bits: port B registered read data.
REQ-011 SHALL have port ready, output, 1 bit: high when the memory clear has finished and accesses are honoured.

Function
REQ-012 SHALL store 2^ADDR_WIDTH words of WIDTH bits.
REQ-013 SHALL, on a clk edge with ready=1 and wea=1, write dina to mem[addra].
REQ-014 SHALL register reads: douta/doutb update on the clk edge after the address is presented (1-cycle latency) and hold between edges.
REQ-015 SHALL make port A write-first: with wea=1, douta on the next edge equals dina.
REQ-016 SHALL bypass on collision: wea=1 and addrb==addra yields doutb = dina on the next edge; otherwise doutb = mem[addrb] from before that edge.
REQ-017 SHALL perform port A and port B reads every cycle regardless of wea; the two addresses are independent.
REQ-018 SHALL implement a two-state controller: CLEAR and RUN.
REQ-019 SHALL, in CLEAR, write zero to one address per cycle, ascending from 0 to 2^ADDR_WIDTH-1, then enter RUN on the following edge; ready=1 only in RUN.
REQ-020 SHALL, in CLEAR, ignore wea/dina and hold douta=doutb=0.
REQ-021 SHALL apply the full ADDR_WIDTH bits of each address; there are no out-of-range addresses and no wrap logic beyond natural address width.

Reset
REQ-022 SHALL, on a clk edge with rst=1, set douta=0, doutb=0, ready=0, the clear counter to 0 and the state to CLEAR; rst overrides any simultaneous write.
REQ-023 SHALL, when rst asserts during CLEAR, restart the clear from address 0.
REQ-024 SHALL, when rst asserts during RUN, discard the write presented on that edge and re-clear the whole array.
REQ-025 SHALL enter CLEAR at power-up without rst; memory contents are defined only after the first completed clear.

Verification
REQ-026 SHALL pass: rst pulse 1 cycle -> ready=0 for exactly 256 cycles (defaults), then ready=1; douta=doutb=0 throughout.
REQ-027 SHALL pass: after ready, write addra=0..4 with dina=3C,30,07,2A,FE (hex) and addrb=addra on the same cycles -> on each following edge douta and doutb equal the written value.
REQ-028 SHALL pass: then wea=0, addrb sweeps 0..4 -> doutb = 3C,30,07,2A,FE one cycle later; addrb=5 -> doutb=00.
REQ-029 SHALL pass: wea=1, addra=1, dina=55, addrb=2 -> doutb=07 and douta=55 next edge; a later read of addr 1 returns 55.
REQ-030 SHALL pass: rst asserted with wea=1, addra=3, dina=AA -> write discarded; after ready, addr 3 reads 00.
REQ-031 SHALL pass: wea=1 while ready=0 (addra=10, dina=77) -> after ready, addr 10 reads 00.
